// File: rtl/fwft_fifo_sdp_if.sv
// rtl/fwft_fifo_sdp_if.sv - producer/consumer handshake bundle for fwft_fifo_sdp
interface fwft_fifo_sdp_if #(
    parameter int Dw = 8,
    parameter int Aw = 6
);
    logic          flush;
    logic [Dw-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic [Dw-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [Aw:0]   count;
    logic          almost_full;

    modport slave (
        input  flush, din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, count, almost_full
    );

    modport master (
        output flush, din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, count, almost_full
    );
endinterface

// File: rtl/fwft_fifo_sdp.sv
// rtl/fwft_fifo_sdp.sv - first-word-fall-through FIFO over a 1-cycle-latency dual-port RAM
module simple_dual_port_ram #(
    parameter int Dw = 8,
    parameter int Aw = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [Aw-1:0] write_addr,
    input  logic [Dw-1:0] data,
    input  logic [Aw-1:0] read_addr,
    output logic [Dw-1:0] q
);
    logic [Dw-1:0] mem [2**Aw];

    // Same-address read/write returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[write_addr] <= data;
        end
        q <= mem[read_addr];
    end
endmodule

module fwft_fifo_sdp #(
    parameter int Dw       = 8,
    parameter int Aw       = 6,
    parameter int AFULL_TH = 2
) (
    input  logic               clk,
    input  logic               reset,
    fwft_fifo_sdp_if.slave     bus
);
    localparam logic [Aw:0] DEPTH = {1'b1, {Aw{1'b0}}};
    localparam logic [Aw:0] ONE   = {{Aw{1'b0}}, 1'b1};
    localparam logic [Aw:0] AF_TH = (Aw+1)'(AFULL_TH);
    localparam logic        AF_RST = (DEPTH <= AF_TH);

    logic [Aw:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [Aw:0]   count, count_nxt, free_nxt;
    logic          push, pop;
    logic          dout_valid_r, din_ready_r, almost_full_r;
    logic [Dw-1:0] q;

    assign push = bus.din_valid & din_ready_r;
    assign pop  = dout_valid_r & bus.dout_ready;

    // Read address looks one word ahead on a pop so q already holds the new head.
    assign rd_ptr_nxt = pop  ? rd_ptr + ONE : rd_ptr;
    assign wr_ptr_nxt = push ? wr_ptr + ONE : wr_ptr;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + ONE;
        end else if (pop && !push) begin
            count_nxt = count - ONE;
        end
    end

    assign free_nxt = DEPTH - count_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            dout_valid_r  <= 1'b0;
            din_ready_r   <= 1'b1;
            almost_full_r <= AF_RST;
        end else if (bus.flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            dout_valid_r  <= 1'b0;
            din_ready_r   <= 1'b1;
            almost_full_r <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            count         <= count_nxt;
            // Compare against the pre-edge write pointer: a word written this
            // edge only becomes readable from the RAM one edge later.
            dout_valid_r  <= (rd_ptr_nxt != wr_ptr);
            din_ready_r   <= ((wr_ptr_nxt - rd_ptr_nxt) != DEPTH);
            almost_full_r <= (free_nxt <= AF_TH);
        end
    end

    simple_dual_port_ram #(
        .Dw(Dw),
        .Aw(Aw)
    ) u_ram (
        .clk       (clk),
        .we        (push & ~bus.flush),
        .write_addr(wr_ptr[Aw-1:0]),
        .data      (bus.din),
        .read_addr (rd_ptr_nxt[Aw-1:0]),
        .q         (q)
    );

    assign bus.dout        = q;
    assign bus.dout_valid  = dout_valid_r;
    assign bus.din_ready   = din_ready_r;
    assign bus.count       = count;
    assign bus.almost_full = almost_full_r;
endmodule

// File: tb/tb_fwft_fifo_sdp.sv
// tb/tb_fwft_fifo_sdp.sv - directed vector bench for fwft_fifo_sdp
module tb_fwft_fifo_sdp;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int NV = 25;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fwft_fifo_sdp_if #(.Dw(DW), .Aw(AW)) bus ();

    fwft_fifo_sdp #(.Dw(DW), .Aw(AW), .AFULL_TH(1)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fl;
        logic [7:0] din;
        logic       dv;
        logic       dr;
        logic       e_vld;
        logic [7:0] e_dout;
        logic       e_rdy;
        logic [2:0] e_cnt;
        logic       e_af;
    } vec_t;

    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int in_idx, out_idx, bubbles, max_cnt, cyc;
        logic seen_valid, push_pre, pop_pre;
        string tag;

        checks = 0;
        errors = 0;

        //            fl  din    dv dr  vld dout  rdy cnt af
        vecs[0]  = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 3'd1, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0};
        vecs[3]  = '{1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0};
        vecs[4]  = '{1'b0, 8'h02, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 3'd2, 1'b0};
        vecs[5]  = '{1'b0, 8'h03, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 3'd3, 1'b1};
        vecs[6]  = '{1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 3'd4, 1'b1};
        vecs[7]  = '{1'b0, 8'h05, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 3'd4, 1'b1};
        vecs[8]  = '{1'b0, 8'h06, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1, 3'd3, 1'b1};
        vecs[9]  = '{1'b0, 8'h06, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 3'd4, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 3'd3, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 3'd2, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h06, 1'b1, 3'd1, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0};
        vecs[14] = '{1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 3'd1, 1'b0};
        vecs[16] = '{1'b0, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 3'd1, 1'b0};
        vecs[18] = '{1'b0, 8'h33, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 3'd2, 1'b0};
        vecs[19] = '{1'b0, 8'h44, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 3'd3, 1'b1};
        vecs[20] = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0};
        vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0};
        vecs[22] = '{1'b0, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b0};
        vecs[23] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h77, 1'b1, 3'd1, 1'b0};
        vecs[24] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0};

        reset          = 1'b0;
        bus.flush      = 1'b0;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_din_ready", bus.din_ready, 1);
        chk("rst_dout_valid", bus.dout_valid, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_almost_full", bus.almost_full, 0);
        reset = 1'b1;
        step();

        for (int i = 0; i < NV; i++) begin
            bus.flush      = vecs[i].fl;
            bus.din        = vecs[i].din;
            bus.din_valid  = vecs[i].dv;
            bus.dout_ready = vecs[i].dr;
            step();
            tag = $sformatf("vec%0d", i);
            chk({tag, "_dout_valid"}, bus.dout_valid, vecs[i].e_vld);
            if (vecs[i].e_vld) begin
                chk({tag, "_dout"}, bus.dout, vecs[i].e_dout);
            end
            chk({tag, "_din_ready"}, bus.din_ready, vecs[i].e_rdy);
            chk({tag, "_count"}, bus.count, vecs[i].e_cnt);
            chk({tag, "_almost_full"}, bus.almost_full, vecs[i].e_af);
        end
        bus.flush = 1'b0;

        // Continuous streaming of 20 words: wraps the 4-deep pointers several times.
        in_idx = 0; out_idx = 0; bubbles = 0; max_cnt = 0; seen_valid = 1'b0;
        bus.dout_ready = 1'b1;
        for (cyc = 0; cyc < 80 && out_idx < 20; cyc++) begin
            bus.din_valid = (in_idx < 20);
            bus.din       = 8'(in_idx);
            push_pre = bus.din_valid & bus.din_ready;
            pop_pre  = bus.dout_valid & bus.dout_ready;
            step();
            if (push_pre) in_idx++;
            if (pop_pre) out_idx++;
            if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
            if (bus.dout_valid) begin
                seen_valid = 1'b1;
                chk($sformatf("stream_dout%0d", out_idx), bus.dout, 32'(out_idx));
            end else if (seen_valid && out_idx < 20) begin
                bubbles++;
            end
        end
        bus.din_valid  = 1'b0;
        bus.dout_ready = 1'b0;
        chk("stream_words_out", out_idx, 20);
        chk("stream_bubbles", bubbles, 0);
        chk("stream_count_le2", max_cnt <= 2, 1);

        // Asynchronous reset with three words stored.
        for (int i = 0; i < 3; i++) begin
            bus.din       = 8'h30 + 8'(i);
            bus.din_valid = 1'b1;
            step();
        end
        bus.din_valid = 1'b0;
        chk("pre_rst_count", bus.count, 3);
        chk("pre_rst_almost_full", bus.almost_full, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_count", bus.count, 0);
        chk("async_rst_dout_valid", bus.dout_valid, 0);
        chk("async_rst_din_ready", bus.din_ready, 1);
        chk("async_rst_almost_full", bus.almost_full, 0);
        #3 reset = 1'b1;
        step();
        bus.din       = 8'h5A;
        bus.din_valid = 1'b1;
        step();
        bus.din_valid = 1'b0;
        chk("post_rst_valid_e1", bus.dout_valid, 0);
        chk("post_rst_count", bus.count, 1);
        step();
        chk("post_rst_valid_e2", bus.dout_valid, 1);
        chk("post_rst_dout", bus.dout, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
